// File: rtl/od_line_receiver.sv
// Open-drain line receiver: per-bit 2-flop sync, glitch filter, sticky fall/overflow flags.
// Optional release-event flags are built when OD_RX_RISE_EVT_EN is defined.
module od_line_receiver #(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned FILTER = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] line,
  input  logic             evt_ack,
  output logic [WIDTH-1:0] asserted,
  output logic [WIDTH-1:0] fall_evt,
  output logic [WIDTH-1:0] evt_ovf,
`ifdef OD_RX_RISE_EVT_EN
  output logic [WIDTH-1:0] rise_evt,
`endif
  output logic             evt_valid
);

  localparam int unsigned CW = $clog2(FILTER + 1);
  localparam logic [CW-1:0] CntLast = CW'(FILTER - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] fall_evt_q, fall_evt_d;
  logic [WIDTH-1:0] evt_ovf_q, evt_ovf_d;

  // Counter only advances while the synchronized level disagrees with the filtered state.
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != state_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          state_d[i] = ~state_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign fall = state_q & ~state_d;

  // A fall on the ack edge survives the clear and is not an overflow.
  always_comb begin
    fall_evt_d = fall_evt_q | fall;
    evt_ovf_d  = evt_ovf_q | (fall_evt_q & fall);
    if (evt_ack) begin
      fall_evt_d = fall;
      evt_ovf_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '1;
      s2_q       <= '1;
      state_q    <= '1;
      fall_evt_q <= '0;
      evt_ovf_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q       <= line;
      s2_q       <= s1_q;
      state_q    <= state_d;
      fall_evt_q <= fall_evt_d;
      evt_ovf_q  <= evt_ovf_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign asserted = ~state_q;
  assign fall_evt = fall_evt_q;
  assign evt_ovf  = evt_ovf_q;

`ifdef OD_RX_RISE_EVT_EN
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] rise_evt_q, rise_evt_d;

  assign rise = ~state_q & state_d;

  always_comb begin
    rise_evt_d = rise_evt_q | rise;
    if (evt_ack) begin
      rise_evt_d = rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_evt_q <= '0;
    end else begin
      rise_evt_q <= rise_evt_d;
    end
  end

  assign rise_evt  = rise_evt_q;
  assign evt_valid = (|fall_evt_q) | (|rise_evt_q);
`else
  assign evt_valid = |fall_evt_q;
`endif

endmodule

// File: tb/tb_od_line_receiver.sv
// Bench for od_line_receiver: window-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized lines/acks/resets.
module tb_od_line_receiver;

  localparam int unsigned WIDTH  = 6;
  localparam int unsigned FILTER = 4;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             evt_ack = 1'b0;
  logic [WIDTH-1:0] line    = '0;
  logic [WIDTH-1:0] asserted, fall_evt, evt_ovf;
  logic             evt_valid;
`ifdef OD_RX_RISE_EVT_EN
  logic [WIDTH-1:0] rise_evt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  od_line_receiver #(
    .WIDTH (WIDTH),
    .FILTER(FILTER)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .line     (line),
    .evt_ack  (evt_ack),
    .asserted (asserted),
    .fall_evt (fall_evt),
    .evt_ovf  (evt_ovf),
`ifdef OD_RX_RISE_EVT_EN
    .rise_evt (rise_evt),
`endif
    .evt_valid(evt_valid)
  );

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a line's filtered state flips once the last FILTER synchronized
  // samples all disagree with it; flags follow the set/clear/retain rules directly.
  logic [WIDTH-1:0] m_s1 = '1, m_s2 = '1, m_state = '1;
  logic [WIDTH-1:0] m_fall = '0, m_ovf = '0, m_rise = '0;
  logic [WIDTH-1:0] hist [$];

  initial begin
    logic [WIDTH-1:0] nxt, f, r, h;
    bit differ;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = '1; m_s2 = '1; m_state = '1;
        m_fall = '0; m_ovf = '0; m_rise = '0;
        hist.delete();
      end else begin
        hist.push_back(m_s2);
        if (hist.size() > FILTER) void'(hist.pop_front());
        nxt = m_state;
        if (hist.size() == FILTER) begin
          for (int i = 0; i < WIDTH; i++) begin
            differ = 1'b1;
            for (int k = 0; k < FILTER; k++) begin
              h = hist[k];
              if (h[i] == m_state[i]) differ = 1'b0;
            end
            if (differ) nxt[i] = ~m_state[i];
          end
        end
        f = m_state & ~nxt;
        r = ~m_state & nxt;
        if (evt_ack) begin
          m_fall = f;
          m_ovf  = '0;
          m_rise = r;
        end else begin
          m_ovf  = m_ovf | (m_fall & f);
          m_fall = m_fall | f;
          m_rise = m_rise | r;
        end
        m_state = nxt;
        m_s2    = m_s1;
        m_s1    = line;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    logic m_valid;
    forever begin
      @(negedge clk);
      m_valid = |m_fall;
`ifdef OD_RX_RISE_EVT_EN
      m_valid = m_valid | (|m_rise);
      check("model rise_evt", rise_evt, m_rise);
`endif
      check("model asserted", asserted, ~m_state);
      check("model fall_evt", fall_evt, m_fall);
      check("model evt_ovf", evt_ovf, m_ovf);
      check("model evt_valid", WIDTH'(evt_valid), WIDTH'(m_valid));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    evt_ack = 1'b1;
    step(1);
    evt_ack = 1'b0;
  endtask

  task automatic pulse(input logic [WIDTH-1:0] low_mask, input int len);
    line = ~low_mask;
    step(len);
    line = '1;
    step(8);
  endtask

  initial begin
    // Reset values with all lines asserted.
    step(3);
    check("reset asserted", asserted, '0);
    check("reset fall_evt", fall_evt, '0);
    check("reset evt_ovf", evt_ovf, '0);
    check("reset evt_valid", WIDTH'(evt_valid), '0);
    line = '1;
    step(1);
    rst_n = 1'b1;
    step(4);

    // Latency: flips after edge 1+FILTER counting the first sampling edge as 0.
    line = 6'b111110;
    step(5);
    check("latency early asserted", asserted, 6'b000000);
    step(1);
    check("latency asserted", asserted, 6'b000001);
    check("latency fall_evt", fall_evt, 6'b000001);
    check("latency evt_valid", WIDTH'(evt_valid), 6'd1);
    line = '1;
    step(8);
    ack_pulse();
    check("ack clears fall_evt", fall_evt, 6'b000000);

    // Glitch rejection, then a just-qualifying pulse.
    pulse(6'b001000, 3);
    check("glitch fall_evt", fall_evt, 6'b000000);
    check("glitch evt_valid", WIDTH'(evt_valid), 6'd0);
    pulse(6'b001000, 4);
    check("min pulse fall_evt", fall_evt, 6'b001000);
    check("min pulse released", asserted, 6'b000000);
    ack_pulse();

    // Overflow.
    pulse(6'b000100, 6);
    pulse(6'b000100, 6);
    check("ovf fall_evt", fall_evt, 6'b000100);
    check("ovf evt_ovf", evt_ovf, 6'b000100);
    ack_pulse();
    check("ovf ack fall_evt", fall_evt, 6'b000000);
    check("ovf ack evt_ovf", evt_ovf, 6'b000000);
    check("ovf ack evt_valid", WIDTH'(evt_valid), 6'd0);

    // Ack on the same edge as a fall on a line whose flag was already set.
    pulse(6'b100000, 6);
    check("collision pre fall_evt", fall_evt, 6'b100000);
    line = 6'b011111;
    step(5);
    evt_ack = 1'b1;
    step(1);
    evt_ack = 1'b0;
    check("collision fall_evt", fall_evt, 6'b100000);
    check("collision evt_ovf", evt_ovf, 6'b000000);
    check("collision evt_valid", WIDTH'(evt_valid), 6'd1);
    line = '1;
    step(8);
    ack_pulse();

    // Mid-operation reset with line[1] held low.
    pulse(6'b010000, 6);
    line = 6'b111101;
    step(3);
    rst_n = 1'b0;
    #1;
    check("midreset fall_evt", fall_evt, 6'b000000);
    check("midreset evt_valid", WIDTH'(evt_valid), 6'd0);
    check("midreset asserted", asserted, 6'b000000);
    step(2);
    rst_n = 1'b1;
    step(5);
    check("post reset early", fall_evt, 6'b000000);
    step(1);
    check("post reset fall_evt", fall_evt, 6'b000010);
    line = '1;
    step(8);
`ifdef OD_RX_RISE_EVT_EN
    check("release rise_evt", rise_evt, 6'b000010);
`endif
    ack_pulse();

    // Randomized lines, acks and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ($urandom_range(5) == 0) line[i] = ~line[i];
      end
      evt_ack = ($urandom_range(15) == 0);
      rst_n   = ($urandom_range(499) != 0);
      step(1);
    end
    rst_n   = 1'b1;
    evt_ack = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
